par2ser_stream: RTL
===================

Name: par2ser_stream

Overview:
- Parametrised, fabric-only parallel-to-serial converter; the vendor-independent successor of the fixed 10-bit SERDES wrapper.
- Accepts LANES parallel words of DATA_WIDTH bits through a valid/ready handshake and shifts them out one bit per enabled clock on LANES serial outputs.
- A one-word holding buffer gives gapless back-to-back streaming.
- Sits between line encoders (8b/10b, TMDS) and low-rate serial pins or a downstream SERDES.

Parameters:
- DATA_WIDTH, 10, bits per word per lane; legal range 2..64.
- LANES, 1, number of lanes; all lanes share one handshake and one bit counter.
- MSB_FIRST, 0, 0 = bit 0 shifted first, 1 = bit DATA_WIDTH-1 shifted first.

Ports:
- clk_i  input  1  single clock for the block.
- rst_n_i  input  1  reset; asynchronous, active-low.
- par_valid_i  input  1  parallel word valid.
- par_ready_o  output  1  holding buffer empty, word can be accepted.
- par_data_i  input  LANES*DATA_WIDTH  lane k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- ser_en_i  input  1  bit strobe; one bit consumed per cycle in which it is high.
- ser_data_o  output  LANES  current serial bit per lane.
- ser_valid_o  output  1  ser_data_o carries word data.
- ser_last_o  output  1  current bit is the final bit of the word.

Behaviour:
- Reset values: par_ready_o=1, ser_data_o=0, ser_valid_o=0, ser_last_o=0; holding buffer empty; FSM in IDLE; bit counter 0.
- Reset is asynchronous and takes effect mid-word: any in-flight or buffered word is discarded and never emitted.
- Storage: holding buffer (buf, buf_full) plus shift register (sh) with bit counter cnt of width $clog2(DATA_WIDTH).
- Accept: par_valid_i && par_ready_o at a rising edge writes buf and sets buf_full.
- par_ready_o = !buf_full, driven from a register. There is no combinational path from ser_en_i or par_valid_i to any output.
- FSM state IDLE:
  - ser_valid_o=0, ser_data_o=0.
  - If buf_full: load sh<=buf, cnt<=0, clear buf_full, go to SHIFT.
- FSM state SHIFT:
  - ser_valid_o=1; ser_data_o per lane = sh bit 0 (MSB_FIRST=0) or bit DATA_WIDTH-1 (MSB_FIRST=1).
  - ser_last_o = (cnt==DATA_WIDTH-1).
  - ser_en_i=0: all state and outputs hold.
  - ser_en_i=1 and cnt<DATA_WIDTH-1: shift sh by one position toward the output end, cnt++.
  - ser_en_i=1 and cnt==DATA_WIDTH-1 and buf_full: reload sh<=buf, cnt<=0, clear buf_full, stay in SHIFT. This is gapless; ser_valid_o stays 1.
  - ser_en_i=1 and cnt==DATA_WIDTH-1 and !buf_full: underrun; go to IDLE, outputs return to idle values next cycle.
- Simultaneous events:
  - Accept and reload cannot coincide, because an accept requires buf empty and a reload requires buf full.
  - A reload in a cycle makes par_ready_o=1 from the next cycle.
- Latency: word accepted at edge N from IDLE; first bit is visible on ser_data_o after edge N+2.
- Throughput: one word per DATA_WIDTH enabled cycles, sustained without gaps when the source responds to ready within DATA_WIDTH-1 cycles.
- All lanes shift in lockstep; lane data are never reordered across lanes.

Optional Feature:
- Macro: PAR2SER_STREAM_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt_o, width 16.
  - Increments on every SHIFT->IDLE underrun transition; saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Single word, DATA_WIDTH=10, LANES=1, MSB_FIRST=0, ser_en_i=1, word 10'h2A5 -> ser_data_o sequence 1,0,1,0,0,1,0,1,0,1 starting 2 cycles after accept; ser_last_o high on the 10th bit only; ser_valid_o drops next cycle.
- Back-to-back words 10'h3FF then 10'h000, source always valid -> 20 consecutive valid bits (ten 1s then ten 0s) with no ser_valid_o gap; par_ready_o low exactly while buf_full.
- ser_en_i toggled 1,0,1,0 during word 10'h155 -> each bit held for 2 cycles; total 20 cycles in SHIFT; no bit lost or duplicated.
- LANES=2, MSB_FIRST=1, par_data_i={10'h200,10'h001} -> lane0 emits 0 nine times then 1; lane1 emits 1 then nine 0s; lanes aligned cycle for cycle.
- rst_n_i asserted after bit 4 of a word with a second word buffered -> outputs go to reset values immediately; after release par_ready_o=1 and neither word is emitted.
- Macro defined, three isolated words with idle gaps -> underrun_cnt_o=3; counter forced near 16'hFFFF with further underruns -> holds at 16'hFFFF.

Source files
------------

// File: rtl/par2ser_stream.sv
// par2ser_stream: parameterised fabric-only parallel-to-serial converter.
// LANES words of DATA_WIDTH bits enter through a valid/ready handshake into a
// one-word holding buffer, then shift out one bit per ser_en_i cycle per lane.
// All lanes share one handshake, one FSM and one bit counter.
// Optional macro PAR2SER_STREAM_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter on underrun_cnt_o.

// Per-lane storage: holding buffer plus shift register.
module par2ser_stream_lane #(
  parameter int DATA_WIDTH = 10,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  buf_we,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout
);
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] sh;

  // Holding buffer captures the accepted word.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)     buf_q <= '0;
    else if (buf_we) buf_q <= din;
  end

  // Shift register: reload from the buffer, or move one bit toward the output end.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)         sh <= '0;
    else if (load)       sh <= buf_q;
    else if (shift) begin
      if (MSB_FIRST != 0) sh <= {sh[DATA_WIDTH-2:0], 1'b0};
      else                sh <= {1'b0, sh[DATA_WIDTH-1:1]};
    end
  end

  assign dout = (MSB_FIRST != 0) ? sh[DATA_WIDTH-1] : sh[0];
endmodule

module par2ser_stream #(
  parameter int DATA_WIDTH = 10,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        par_valid_i,
  output logic                        par_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] par_data_i,
  input  logic                        ser_en_i,
  output logic [LANES-1:0]            ser_data_o,
  output logic                        ser_valid_o,
  output logic                        ser_last_o
`ifdef PAR2SER_STREAM_UNDERRUN_CNT_EN
  , output logic [15:0]               underrun_cnt_o
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                             state, state_n;
  logic [CW-1:0]                      cnt, cnt_n;
  logic                               buf_full, buf_full_n;
  logic                               ready_q;
  logic                               accept, load, shift, at_last;
  logic [LANES-1:0][DATA_WIDTH-1:0]   words;
  logic [LANES-1:0]                   lane_bit;
  logic [LANES-1:0]                   ser_data_q;
  logic                               ser_valid_q, ser_last_q;

  assign words   = par_data_i;
  assign accept  = par_valid_i && ready_q;
  assign at_last = (cnt == LAST_IDX);

  // Lane array: every lane sees the same load/shift strobes, so they stay in lockstep.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    par2ser_stream_lane #(.DATA_WIDTH(DATA_WIDTH), .MSB_FIRST(MSB_FIRST)) u_lane (
      .gclk   (clk_i),
      .grst_n (rst_n_i),
      .buf_we (accept),
      .load   (load),
      .shift  (shift),
      .din    (words[k]),
      .dout   (lane_bit[k])
    );
  end

  // Control state: FSM, bit counter, buffer flag and registered ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_full <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      buf_full <= buf_full_n;
      ready_q  <= !buf_full_n;
    end
  end

  // Next-state logic; accept and reload never coincide since they need opposite buf_full.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    buf_full_n = buf_full;
    load       = 1'b0;
    shift      = 1'b0;
    if (accept) buf_full_n = 1'b1;
    case (state)
      IDLE: begin
        if (buf_full) begin
          load       = 1'b1;
          cnt_n      = '0;
          buf_full_n = 1'b0;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en_i) begin
          if (!at_last) begin
            shift = 1'b1;
            cnt_n = cnt + CW'(1);
          end else if (buf_full) begin
            load       = 1'b1;
            cnt_n      = '0;
            buf_full_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output stage: registered copy of the current bit so no input reaches an output combinationally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ser_data_q  <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      ser_data_q  <= (state == SHIFT) ? lane_bit : '0;
      ser_valid_q <= (state == SHIFT);
      ser_last_q  <= (state == SHIFT) && at_last;
    end
  end

  assign par_ready_o = ready_q;
  assign ser_data_o  = ser_data_q;
  assign ser_valid_o = ser_valid_q;
  assign ser_last_o  = ser_last_q;

`ifdef PAR2SER_STREAM_UNDERRUN_CNT_EN
  logic        underrun;
  logic [15:0] underrun_cnt;

  assign underrun = (state == SHIFT) && ser_en_i && at_last && !buf_full;

  // Saturating count of SHIFT->IDLE underrun transitions.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                             underrun_cnt <= '0;
    else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end

  assign underrun_cnt_o = underrun_cnt;
`endif
endmodule
